regfile_sequencer: RTL
======================

# regfile_sequencer

Control sequencer that is the initiator on the register-file select interface. It fetches 8-bit instructions through a ready/valid memory handshake using the PC register (R7) as the address source. It then drives DSEL/ASEL/BSEL and an ALU opcode so the register file and external ALU increment PC and execute register-to-register MOV/ADD/SUB. It sits between instruction memory and the REGFILE/ALU datapath as the CPU's control unit.

## Interface
Parameters:
- none; all widths are fixed by the 8-register, 8-bit datapath.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RST_N  input  1  synchronous, active-low reset, sampled on posedge CLK.
- START  input  1  one-cycle run request; honoured only in IDLE.
- INSTR  input  8  instruction word from memory; valid when MEM_RDY=1.
- MEM_RDY  input  1  memory response; INSTR is valid in the same cycle.
- MEM_RD  output  1  memory read request; address is the A bus (PC).
- DSEL  output  3  register-file write select; 0 means no write.
- ASEL  output  3  register-file A-bus select; 0 selects DIN.
- BSEL  output  3  register-file B-bus select; 0 selects DIN.
- ALU_OP  output  2  00 PASS_B, 01 ADD (A+B), 10 SUB (A−B), 11 INC_A (A+1); results are 8-bit and wrap modulo 256.
- IR  output  8  latched current instruction.
- BUSY  output  1  high in FETCH, INCPC and EXEC.
- HALTED  output  1  high in HALT.

## Operation
- Instruction format: IR[7:6] opcode, IR[5:3] dst, IR[2:0] src.
  - 00 MOV: dst←src.
  - 01 ADD: dst←dst+src.
  - 10 SUB: dst←dst−src.
  - 11 HALT: dst and src fields are ignored.
- src=0 reads DIN, which gives load-immediate/external input for free. dst=0 produces DSEL=0, so the result is discarded (a NOP write).
- States are IDLE, FETCH, INCPC, EXEC and HALT, held in a posedge state register.
- Outputs are Moore decodes of state plus IR:
  - IDLE: all selects 0, ALU_OP=00, MEM_RD=0, BUSY=0.
  - FETCH: ASEL=7, MEM_RD=1, DSEL=0, BSEL=0, ALU_OP=00.
  - INCPC: ASEL=7, BSEL=0, ALU_OP=11, DSEL=7.
  - EXEC: ASEL=IR[5:3], BSEL=IR[2:0], ALU_OP=IR[7:6], DSEL=IR[5:3].
  - HALT: all selects 0, MEM_RD=0, BUSY=0, HALTED=1.
- State transitions:
  - IDLE→FETCH when START=1.
  - FETCH→FETCH while MEM_RDY=0.
  - FETCH with MEM_RDY=1: IR←INSTR. Next state is HALT if INSTR[7:6]=11, otherwise INCPC.
  - INCPC→EXEC.
  - EXEC→FETCH.
  - HALT→HALT until reset.
- A HALT instruction does not increment PC; PC keeps the HALT instruction's address.
- START outside IDLE is ignored. MEM_RDY outside FETCH is ignored.
- DSEL is nonzero for exactly one cycle per write, so there is never more than one register write per cycle.

## Timing
- Reset (RST_N=0 at a posedge):
  - Next state is IDLE and IR=0.
  - Outputs become DSEL=ASEL=BSEL=0, ALU_OP=00, MEM_RD=0, BUSY=0, HALTED=0.
  - Reset takes priority over START, MEM_RDY and any in-flight state. Register-file contents are untouched.
- Select outputs change only after posedge CLK. REGFILE captures on negedge, so DSEL and the RIN value must settle within half a cycle.
- Latency from START to the first MEM_RD: 1 cycle.
- Instruction throughput: (1 + memory wait cycles) + 1 (INCPC) + 1 (EXEC). With zero wait states this is 3 cycles per instruction.
- MEM_RD stays high continuously from FETCH entry through the cycle in which MEM_RDY=1, then deasserts the next cycle.
- MEM_RDY=1 in the first FETCH cycle is accepted, giving zero wait states.
- PC wraps 0xFF→0x00 via INC_A. The sequencer does no special handling.

## Test plan
- Reset mid-EXEC: assert RST_N=0 while DSEL=3 → next cycle DSEL=0, BUSY=0, IR=0, state IDLE; a START two cycles later begins FETCH with MEM_RD=1 one cycle later.
- Zero-wait MOV: START, then INSTR=8'h0A (MOV R1←R2) with MEM_RDY=1 on the first FETCH cycle → INCPC cycle shows ASEL=7/ALU_OP=11/DSEL=7; EXEC cycle shows ASEL=1/BSEL=2/ALU_OP=00/DSEL=1; next cycle MEM_RD=1.
- Memory wait: hold MEM_RDY=0 for 4 cycles then 1 with INSTR=8'h50 (ADD R2←R2+DIN) → MEM_RD high for 5 cycles, DSEL=0 throughout; EXEC shows ASEL=2/BSEL=0/ALU_OP=01/DSEL=2.
- HALT: INSTR=8'hC0 → no INCPC cycle (DSEL never 7), HALTED=1 next cycle and stays high; START pulses and MEM_RDY pulses have no effect.
- Ignored inputs: pulse START during INCPC and MEM_RDY during EXEC → state sequence and outputs are unchanged from the nominal run.
- dst=0 SUB: INSTR=8'h83 → EXEC shows ASEL=0/BSEL=3/ALU_OP=10/DSEL=0 (no write), then FETCH resumes.

Source files
------------

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sequencer
// Purpose  : Control unit for an 8 x 8-bit register file plus external ALU.
//            It fetches an 8-bit instruction over a ready/valid memory
//            handshake, using R7 (PC) on the A bus as the fetch address. It
//            then steers the register-file selects and the ALU opcode to
//            increment PC and execute MOV/ADD/SUB, or stops on HALT.
// Ports    : clk_i      - clock, every state update on the rising edge
//            rst_n_i    - synchronous active-low reset
//            start_i    - one-cycle run request, honoured only in IDLE
//            instr_i    - instruction word, valid while mem_rdy_i=1
//            mem_rdy_i  - memory response strobe
//            mem_rd_o   - memory read request (address = A bus = PC)
//            dsel_o     - register write select (0 = no write)
//            asel_o     - A-bus select (0 = DIN)
//            bsel_o     - B-bus select (0 = DIN)
//            alu_op_o   - 00 PASS_B, 01 ADD, 10 SUB, 11 INC_A
//            ir_o       - latched current instruction
//            busy_o     - high in FETCH, INCPC and EXEC
//            halted_o   - high in HALT
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sequencer (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] instr_i,
    input  logic       mem_rdy_i,
    output logic       mem_rd_o,
    output logic [2:0] dsel_o,
    output logic [2:0] asel_o,
    output logic [2:0] bsel_o,
    output logic [1:0] alu_op_o,
    output logic [7:0] ir_o,
    output logic       busy_o,
    output logic       halted_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_INCPC = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] PC_REG   = 3'd7;
    localparam logic [1:0] OP_PASSB = 2'b00;
    localparam logic [1:0] OP_INCA  = 2'b11;
    localparam logic [1:0] OP_HALT  = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state plus Moore output decode. Outputs depend only on the
    // registered state and IR, so the selects settle shortly after the
    // rising edge, well before the register file captures on the falling one.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        mem_rd_o = 1'b0;
        dsel_o   = 3'd0;
        asel_o   = 3'd0;
        bsel_o   = 3'd0;
        alu_op_o = OP_PASSB;
        busy_o   = 1'b0;
        halted_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                asel_o   = PC_REG;
                mem_rd_o = 1'b1;
                busy_o   = 1'b1;
                if (mem_rdy_i) begin
                    ir_d = instr_i;
                    // HALT skips INCPC so PC keeps pointing at the HALT word.
                    state_d = (instr_i[7:6] == OP_HALT) ? S_HALT : S_INCPC;
                end
            end

            S_INCPC: begin
                asel_o   = PC_REG;
                bsel_o   = 3'd0;
                alu_op_o = OP_INCA;
                dsel_o   = PC_REG;
                busy_o   = 1'b1;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                // The opcode field maps directly onto the ALU encoding for
                // MOV/ADD/SUB; a dst of 0 yields dsel 0, i.e. no write.
                asel_o   = ir_q[5:3];
                bsel_o   = ir_q[2:0];
                alu_op_o = ir_q[7:6];
                dsel_o   = ir_q[5:3];
                busy_o   = 1'b1;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                halted_o = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ir_o = ir_q;

endmodule
`default_nettype wire
